// File: rtl/fifo_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_word_packer: drains a registered-read FIFO and packs PACK_RATIO     |
// | entries per output word. PACKER_TIMEOUT_EN adds an idle partial flush.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_word_packer #(
  parameter int DATA_SIZE      = 16,
  parameter int PACK_RATIO     = 2,
  parameter int OUT_SIZE       = DATA_SIZE * PACK_RATIO,
  parameter int LANE_W         = $clog2(PACK_RATIO + 1),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  output logic                 o_fifo_en,
  output logic                 o_fifo_read,
  input  logic                 i_fifo_empty,
  input  logic [DATA_SIZE-1:0] i_fifo_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_SIZE-1:0]  o_data,
  output logic [LANE_W-1:0]    o_lanes
);

  localparam logic [LANE_W-1:0] FULL      = LANE_W'(PACK_RATIO);
  localparam logic [LANE_W:0]   FULL_WIDE = (LANE_W + 1)'(PACK_RATIO);

  logic [OUT_SIZE-1:0] acc_q, acc_d, acc_base;
  logic [LANE_W-1:0]   fill_q, fill_d, fill_base;
  logic                pend_q, pend_d;
  logic                rd_q, rd_d;
  logic                valid_q, valid_d;
  logic [OUT_SIZE-1:0] data_q, data_d;
  logic [LANE_W-1:0]   lanes_q, lanes_d;
  logic                out_free;
  logic                move;
  logic                flush;
  logic [LANE_W:0]     budget;

  assign out_free = !valid_q || i_ready;
  assign move     = (fill_q == FULL) && out_free;

`ifdef PACKER_TIMEOUT_EN
  localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] idle_q, idle_d;

  assign flush = (idle_q == IDLE_MAX) && out_free && !pend_q && !rd_q &&
                 (fill_q != '0) && (fill_q != FULL);

  always_comb begin
    idle_d = idle_q;
    if (pend_q || (fill_q == '0) || (fill_q == FULL) || flush) begin
      idle_d = '0;
    end else if (!rd_q && (idle_q != IDLE_MAX)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign flush          = 1'b0;
`endif

  always_comb begin
    valid_d   = valid_q && !i_ready;
    data_d    = data_q;
    lanes_d   = lanes_q;
    acc_base  = acc_q;
    fill_base = fill_q;
    // Clearing the accumulator on every move keeps unused lanes of a later partial word zero.
    if (move || flush) begin
      valid_d   = 1'b1;
      data_d    = acc_q;
      lanes_d   = fill_q;
      acc_base  = '0;
      fill_base = '0;
    end
    acc_d  = acc_base;
    fill_d = fill_base;
    if (pend_q) begin
      for (int k = 0; k < PACK_RATIO; k++) begin
        if (fill_base == LANE_W'(k)) begin
          acc_d[k*DATA_SIZE +: DATA_SIZE] = i_fifo_data;
        end
      end
      fill_d = fill_base + 1'b1;
    end
    pend_d = rd_q;
    // The read presented now lands after this edge, so it already owns a lane.
    budget = {1'b0, fill_d} + {{LANE_W{1'b0}}, rd_q};
    rd_d   = !i_fifo_empty && !flush && (budget < FULL_WIDE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_q   <= '0;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      lanes_q <= '0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      lanes_q <= lanes_d;
    end
  end

  assign o_fifo_en   = !i_reset;
  assign o_fifo_read = rd_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_lanes     = lanes_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_word_packer: FIFO model, vector table and stream scoreboard.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fifo_word_packer;
  localparam int DS = 16;
  localparam int P  = 2;
  localparam int OS = DS * P;
  localparam int LW = $clog2(P + 1);

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          o_fifo_en;
  logic          o_fifo_read;
  logic          fifo_empty = 1'b1;
  logic [DS-1:0] fdata;
  logic          o_valid;
  logic          i_ready;
  logic [OS-1:0] o_data;
  logic [LW-1:0] o_lanes;

  fifo_word_packer #(.DATA_SIZE(DS), .PACK_RATIO(P), .TIMEOUT_CYCLES(64)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .o_fifo_en(o_fifo_en),
    .o_fifo_read(o_fifo_read), .i_fifo_empty(fifo_empty), .i_fifo_data(fdata),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_lanes(o_lanes)
  );

  always #5 i_clk = ~i_clk;

  // FIFO model: registered read data; empty already discounts the read being presented.
  logic [DS-1:0] fq[$];
  logic [DS-1:0] mdl[$];
  int            rd_cnt = 0;
  logic          under = 1'b0;

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fdata <= '0;
    end else if (o_fifo_read) begin
      rd_cnt <= rd_cnt + 1;
      if (fq.size() == 0) under <= 1'b1;
      else fdata <= fq.pop_front();
    end
  end

  always begin
    @(negedge i_clk);
    #2;
    fifo_empty = (fq.size() <= (o_fifo_read ? 1 : 0));
  end

  typedef struct {
    logic [DS-1:0] e0;
    logic [DS-1:0] e1;
    logic [OS-1:0] exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   words = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // Reference: every P consecutive pushed entries form one word, first entry in the LSBs.
  task automatic tick(input logic rdy);
    logic [OS-1:0] exp;
    @(negedge i_clk);
    i_ready = rdy;
    #1;
    if (mon_en && o_valid && i_ready) begin
      if (mdl.size() < P) begin
        chk("word_without_entries", 64'(mdl.size()), 64'(P));
      end else begin
        exp = '0;
        for (int k = 0; k < P; k++) exp = exp | (OS'(mdl.pop_front()) << (k * DS));
        chk("stream_word", 64'(o_data), 64'(exp));
        chk("stream_lanes", 64'(o_lanes), 64'(P));
      end
      words++;
    end
  endtask

  task automatic push(input logic [DS-1:0] v);
    fq.push_back(v);
    mdl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    fq.delete();
    mdl.delete();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 120 && !seen; c++) begin
      tick(1'b1);
      if (o_valid) seen = 1'b1;
    end
    if (!seen) chk(nm, 64'(0), 64'(1));
  endtask

  initial begin
    vec_t vecs[5];
    logic seen;
    int   r0, w0;

    vecs[0] = '{16'h1111, 16'h2222, 32'h22221111};
    vecs[1] = '{16'h3333, 16'h4444, 32'h44443333};
    vecs[2] = '{16'h0000, 16'hFFFF, 32'hFFFF0000};
    vecs[3] = '{16'hFFFF, 16'h0001, 32'h0001FFFF};
    vecs[4] = '{16'hA5A5, 16'h5A5A, 32'h5A5AA5A5};

    i_reset = 1'b1;
    i_ready = 1'b0;
    #1;
    chk("reset_fifo_en", 64'(o_fifo_en), 64'(0));
    chk("reset_valid", 64'(o_valid), 64'(0));
    chk("reset_read", 64'(o_fifo_read), 64'(0));
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk("fifo_en_run", 64'(o_fifo_en), 64'(1));

    // Vector table: two entries in, one packed word out.
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].e0);
      push(vecs[i].e1);
      wait_valid("vec_timeout", seen);
      if (seen) begin
        chk("vec_data", 64'(o_data), 64'(vecs[i].exp));
        chk("vec_lanes", 64'(o_lanes), 64'(P));
      end
      tick(1'b1);
      chk("vec_valid_drop", 64'(o_valid), 64'(0));
      mdl.delete();
    end

    // Steady stream of four entries.
    do_reset();
    mon_en = 1'b1;
    w0 = words;
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    repeat (20) tick(1'b1);
    chk("stream_word_count", 64'(words - w0), 64'(2));

    // Backpressure: output held, reads stop once the accumulator is full too.
    do_reset();
    r0 = rd_cnt;
    for (int i = 1; i <= 6; i++) push(DS'(i * 16'h1111));
    repeat (14) begin
      tick(1'b0);
      if (o_valid) chk("bp_hold_data", 64'(o_data), 64'h22221111);
    end
    chk("bp_valid", 64'(o_valid), 64'(1));
    chk("bp_reads", 64'(rd_cnt - r0), 64'(4));
    chk("bp_fifo_left", 64'(fq.size()), 64'(2));
    w0 = words;
    repeat (20) tick(1'b1);
    chk("bp_word_count", 64'(words - w0), 64'(3));
    chk("bp_model_empty", 64'(mdl.size()), 64'(0));

    // Asynchronous reset in the middle of a fill.
    do_reset();
    push(16'h7777); push(16'h8888); push(16'h9999);
    repeat (10) tick(1'b0);
    @(negedge i_clk);
    #3;
    i_reset = 1'b1;
    fq.delete();
    mdl.delete();
    #1;
    chk("mid_reset_valid", 64'(o_valid), 64'(0));
    chk("mid_reset_data", 64'(o_data), 64'(0));
    chk("mid_reset_lanes", 64'(o_lanes), 64'(0));
    chk("mid_reset_read", 64'(o_fifo_read), 64'(0));
    chk("mid_reset_en", 64'(o_fifo_en), 64'(0));
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    w0 = words;
    push(16'h5555); push(16'h6666);
    repeat (20) tick(1'b1);
    chk("post_reset_words", 64'(words - w0), 64'(1));

    // Single entry: one read, then nothing while the FIFO is empty.
    do_reset();
    mon_en = 1'b0;
    r0 = rd_cnt;
    push(16'hABCD);
    repeat (20) tick(1'b1);
    chk("single_reads", 64'(rd_cnt - r0), 64'(1));
`ifdef PACKER_TIMEOUT_EN
    wait_valid("flush_timeout", seen);
    if (seen) begin
      chk("flush_data", 64'(o_data), 64'h0000ABCD);
      chk("flush_lanes", 64'(o_lanes), 64'(1));
    end
`else
    chk("single_no_valid", 64'(o_valid), 64'(0));
`endif

    // Randomized stream against the reference scoreboard.
    do_reset();
    mon_en = 1'b1;
    w0 = words;
    for (int c = 0; c < 2000; c++) begin
      tick($urandom_range(0, 3) != 0);
      if (fq.size() < 6 && $urandom_range(0, 1) == 1) push(DS'($urandom));
    end
    if ((mdl.size() % P) != 0) push(DS'($urandom));
    repeat (40) tick(1'b1);
    chk("rand_model_drained", 64'(mdl.size()), 64'(0));
    chk("rand_fifo_drained", 64'(fq.size()), 64'(0));
    chk("rand_words_seen", 64'(words - w0 > 100), 64'(1));
    chk("fifo_underflow", 64'(under), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
